// File: rtl/bep_pkg.sv
// +----------------------------------------------------------------------------
// | bep_pkg : shared state encoding and default sizing for the BEP frame path
// | Rev 1.0 : initial release
// +----------------------------------------------------------------------------
`default_nettype none

package bep_pkg;

    localparam int DEPTH_DEFAULT   = 16;
    localparam int TIMEOUT_DEFAULT = 255;
    localparam int CNT_W           = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECEIVE = 2'd1,
        ST_DONE    = 2'd2,
        ST_HALTED  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/bep_frame_buffer.sv
// +----------------------------------------------------------------------------
// | bep_frame_buffer : DEPTH x 8 register file, one write port, registered read
// | Rev 1.0 : initial release
// +----------------------------------------------------------------------------
`default_nettype none

module bep_frame_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    // Read samples the pre-write contents, so a same-cycle write returns old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
            rd_data <= 8'h00;
        end else if (ena) begin
            if (wr_en) begin
                mem[wr_addr] <= wr_data;
            end
            rd_data <= mem[rd_addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/bep_frame_controller.sv
// +----------------------------------------------------------------------------
// | bep_frame_controller : frames decoded bytes into a buffer, ends on line idle
// | Rev 1.0 : initial release
// +----------------------------------------------------------------------------
`default_nettype none

module bep_frame_controller
    import bep_pkg::*;
#(
    parameter int DEPTH          = DEPTH_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ena,
    input  logic                         halt,
    input  logic                         frame_begin,
    input  logic                         byte_valid,
    input  logic [7:0]                   byte_data,
    input  logic                         line_edge,
    input  logic [$clog2(DEPTH)-1:0]     rd_addr,
    output logic [7:0]                   rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   frame_len,
    output logic                         frame_done,
    output logic                         overflow,
    output logic                         busy,
    output logic                         decoder_en
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0]    LEN_FULL = LW'(DEPTH);
    localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT_CYCLES);

    state_t           state;
    state_t           state_nx;
    logic             restart;
    logic             wr_en;
    logic             drop;
    logic [LW-1:0]    len;
    logic             ovf;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (ena) begin
            state <= state_nx;
        end
    end

    // halt outranks everything; a restarting frame_begin swallows a coincident byte.
    always_comb begin
        state_nx = state;
        restart  = 1'b0;
        wr_en    = 1'b0;
        drop     = 1'b0;
        if (halt) begin
            state_nx = ST_HALTED;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (frame_begin) begin
                        restart  = 1'b1;
                        state_nx = ST_RECEIVE;
                    end
                end
                ST_RECEIVE: begin
                    if (frame_begin) begin
                        restart = 1'b1;
                    end else begin
                        if (byte_valid) begin
                            wr_en = (len < LEN_FULL);
                            drop  = (len >= LEN_FULL);
                        end
                        if (cnt == TO_VAL) begin
                            state_nx = ST_DONE;
                        end
                    end
                end
                ST_HALTED: begin
                    state_nx = ST_IDLE;
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len <= '0;
            ovf <= 1'b0;
            cnt <= '0;
        end else if (ena) begin
            if (restart) begin
                len <= '0;
                ovf <= 1'b0;
                cnt <= '0;
            end else begin
                if (wr_en) begin
                    len <= len + LW'(1);
                end
                if (drop) begin
                    ovf <= 1'b1;
                end
                if (state == ST_RECEIVE && !halt) begin
                    if (line_edge || byte_valid) begin
                        cnt <= '0;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    bep_frame_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .wr_en   (wr_en),
        .wr_addr (len[AW-1:0]),
        .wr_data (byte_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign frame_len  = len;
    assign overflow   = ovf;
    assign busy       = (state == ST_RECEIVE);
    assign frame_done = (state == ST_DONE);
    assign decoder_en = (state != ST_HALTED);

endmodule

`default_nettype wire
